// File: rtl/wb_write_arb.sv
// Register-file write-port arbiter: W-stage writes win, multi-cycle results queue in a FIFO.
// A starvation counter forces a one-cycle W stall to drain the head. `WB_PEND_EN adds pend1/pend2.
module wb_write_arb #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned STARVE_MAX = 7
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_we,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   input  logic [31:0] wb_pc8,
   input  logic        md_valid,
   input  logic [4:0]  md_addr,
   input  logic [31:0] md_data,
   input  logic [31:0] md_pc8,
   output logic        md_ready,
   output logic        rf_we,
   output logic [4:0]  rf_addr,
   output logic [31:0] rf_data,
   output logic [31:0] rf_pc8,
   output logic        wb_stall,
   input  logic [4:0]  rd1_addr,
   input  logic [4:0]  rd2_addr,
   output logic        pend1,
   output logic        pend2
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [4:0]       addr_q [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [31:0]      pc8_q  [DEPTH];
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             stall_q, stall_d;
   logic             alive_q;
   logic             head_vld, head_sel, push, pop;

   assign head_vld = valid_q[rd_ptr_q];
   // alive_q holds md_ready low until the first edge after reset release
   assign md_ready = alive_q & ~(&valid_q);
   assign push     = md_valid & md_ready & (md_addr != 5'd0);
   assign head_sel = head_vld & (stall_q | ~wb_we);
   assign pop      = reset & head_sel;
   assign wb_stall = stall_q;

   always_comb begin
      valid_d = valid_q;
      if (pop)  valid_d[rd_ptr_q] = 1'b0;
      if (push) valid_d[wr_ptr_q] = 1'b1;
   end

   always_comb begin
      cnt_d   = cnt_q;
      stall_d = 1'b0;
      if (!head_vld || pop) begin
         cnt_d = '0;
      end else if (wb_we && !stall_q) begin
         if (cnt_q == CntW'(STARVE_MAX - 1)) begin
            cnt_d   = '0;
            stall_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         valid_q  <= '0;
         cnt_q    <= '0;
         stall_q  <= 1'b0;
         alive_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
         alive_q <= 1'b1;
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_ptr_q] <= md_addr;
         data_q[wr_ptr_q] <= md_data;
         pc8_q[wr_ptr_q]  <= md_pc8;
      end
   end

   // reset gates the combinational W path so the port is quiet while reset is held
   always_comb begin
      rf_we   = 1'b0;
      rf_addr = '0;
      rf_data = '0;
      rf_pc8  = '0;
      if (reset) begin
         if (head_sel) begin
            rf_we   = 1'b1;
            rf_addr = addr_q[rd_ptr_q];
            rf_data = data_q[rd_ptr_q];
            rf_pc8  = pc8_q[rd_ptr_q];
         end else if (wb_we) begin
            rf_we   = 1'b1;
            rf_addr = wb_addr;
            rf_data = wb_data;
            rf_pc8  = wb_pc8;
         end
      end
   end

`ifdef WB_PEND_EN
   always_comb begin
      pend1 = 1'b0;
      pend2 = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (valid_q[i] && (addr_q[i] == rd1_addr)) pend1 = 1'b1;
         if (valid_q[i] && (addr_q[i] == rd2_addr)) pend2 = 1'b1;
      end
      if (rd1_addr == 5'd0) pend1 = 1'b0;
      if (rd2_addr == 5'd0) pend2 = 1'b0;
   end
`else
   logic unused_rd;
   assign unused_rd = ^{rd1_addr, rd2_addr};
   assign pend1     = 1'b0;
   assign pend2     = 1'b0;
`endif

endmodule

// File: tb/tb_wb_write_arb.sv
// Directed bench for wb_write_arb: scoreboard of queued writes plus cycle-exact directed checks.
module tb_wb_write_arb;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data, wb_pc8;
   logic        md_valid;
   logic [4:0]  md_addr;
   logic [31:0] md_data, md_pc8;
   logic        md_ready;
   logic        rf_we;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data, rf_pc8;
   logic        wb_stall;
   logic [4:0]  rd1_addr, rd2_addr;
   logic        pend1, pend2;

`ifdef WB_PEND_EN
   localparam logic PendOn = 1'b1;
`else
   localparam logic PendOn = 1'b0;
`endif

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      logic [31:0] pc8;
   } sb_entry_t;

   sb_entry_t sb_q[$];
   int        pass_cnt = 0;
   int        total    = 0;
   int        writes;

   wb_write_arb #(.DEPTH(4), .STARVE_MAX(7)) dut (
      .clk      (clk),
      .reset    (reset),
      .wb_we    (wb_we),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .wb_pc8   (wb_pc8),
      .md_valid (md_valid),
      .md_addr  (md_addr),
      .md_data  (md_data),
      .md_pc8   (md_pc8),
      .md_ready (md_ready),
      .rf_we    (rf_we),
      .rf_addr  (rf_addr),
      .rf_data  (rf_data),
      .rf_pc8   (rf_pc8),
      .wb_stall (wb_stall),
      .rd1_addr (rd1_addr),
      .rd2_addr (rd2_addr),
      .pend1    (pend1),
      .pend2    (pend2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Scoreboard: queue-path issues must match accepted offers in order; W path must be exact.
   always @(negedge clk) begin
      if (reset) begin
         if (!rf_we) begin
            check("idle_zero", rf_data | rf_pc8 | {27'd0, rf_addr}, 32'd0);
         end else if (wb_we && !wb_stall) begin
            check("w_addr", {27'd0, rf_addr}, {27'd0, wb_addr});
            check("w_data", rf_data, wb_data);
            check("w_pc8", rf_pc8, wb_pc8);
         end else begin
            check("sb_nonempty", (sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
               sb_entry_t e;
               e = sb_q.pop_front();
               check("q_addr", {27'd0, rf_addr}, {27'd0, e.addr});
               check("q_data", rf_data, e.data);
               check("q_pc8", rf_pc8, e.pc8);
            end
         end
         if (md_valid && md_ready && md_addr != 5'd0)
            sb_q.push_back('{addr: md_addr, data: md_data, pc8: md_pc8});
      end
   end

   initial begin
      reset    = 1'b0;
      wb_we    = 1'b1;
      wb_addr  = 5'd3;
      wb_data  = 32'h3333_3333;
      wb_pc8   = 32'h0000_0030;
      md_valid = 1'b1;
      md_addr  = 5'd7;
      md_data  = 32'h7777_7777;
      md_pc8   = 32'h0000_0070;
      rd1_addr = 5'd7;
      rd2_addr = 5'd7;
      repeat (2) @(negedge clk);
      check("rst_rf_we", rf_we, 0);
      check("rst_rf_addr", {27'd0, rf_addr}, 0);
      check("rst_rf_data", rf_data, 0);
      check("rst_md_ready", md_ready, 0);
      check("rst_wb_stall", wb_stall, 0);
      check("rst_pend", {pend1, pend2}, 0);

      @(posedge clk); #2;
      reset = 1'b1; wb_we = 1'b0; md_valid = 1'b0;
      rd1_addr = 5'd0; rd2_addr = 5'd0;
      @(negedge clk);
      check("ready_before_edge", md_ready, 0);
      @(posedge clk); #1;
      check("ready_after_edge", md_ready, 1);

      // single offer, W idle: one-cycle latency
      md_valid = 1'b1; md_addr = 5'd8; md_data = 32'h1111_1111; md_pc8 = 32'h0000_1008;
      @(negedge clk);
      check("no_bypass", rf_we, 0);
      @(posedge clk); #1;
      md_valid = 1'b0;
      @(negedge clk);
      check("lat_rf_we", rf_we, 1);
      check("lat_rf_addr", {27'd0, rf_addr}, 8);
      check("lat_rf_data", rf_data, 32'h1111_1111);
      @(posedge clk); #1;
      @(negedge clk);
      check("single_issue", rf_we, 0);

      // zero-address offer is swallowed
      @(posedge clk); #1;
      md_valid = 1'b1; md_addr = 5'd0; md_data = 32'hDEAD_BEEF; md_pc8 = 32'h0000_2008;
      @(negedge clk);
      check("zero_ready", md_ready, 1);
      @(posedge clk); #1;
      md_valid = 1'b0;
      @(negedge clk);
      check("zero_no_write", rf_we, 0);

      // fill to DEPTH while W owns the port
      @(posedge clk); #1;
      wb_we = 1'b1; wb_addr = 5'd20; wb_data = 32'hC0DE_0000; wb_pc8 = 32'h0000_0200;
      for (int i = 1; i <= 4; i++) begin
         md_valid = 1'b1; md_addr = 5'(i);
         md_data = 32'hA000_0000 + 32'(i); md_pc8 = 32'h0000_0300 + 32'(8 * i);
         @(negedge clk);
         check("ready_fill", md_ready, 1);
         @(posedge clk); #1;
      end
      md_addr = 5'd5; md_data = 32'hA000_0005; md_pc8 = 32'h0000_0328;
      @(negedge clk);
      check("ready_full", md_ready, 0);
      @(posedge clk); #1;
      wb_we = 1'b0;
      @(negedge clk);
      check("ready_no_credit", md_ready, 0);
      check("head_first", {27'd0, rf_addr}, 1);
      @(posedge clk); #1;
      @(negedge clk);
      check("ready_after_pop", md_ready, 1);
      @(posedge clk); #1;
      md_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("drain_done", sb_q.size(), 0);
      check("drain_idle", rf_we, 0);

      // starvation: $5 queued, W busy 8 cycles, stall in the 8th
      @(posedge clk); #1;
      md_valid = 1'b1; md_addr = 5'd5; md_data = 32'h5555_5555; md_pc8 = 32'h0000_5008;
      wb_we = 1'b1; wb_addr = 5'd30; wb_pc8 = 32'h0000_0400; wb_data = 32'hB000_0000;
      rd1_addr = 5'd5; rd2_addr = 5'd0;
      @(posedge clk); #1;
      md_valid = 1'b0;
      for (int s = 1; s <= 8; s++) begin
         wb_data = 32'hB000_0000 + 32'(s);
         @(negedge clk);
         check("stall", wb_stall, (s == 8));
         check("stall_port", {27'd0, rf_addr}, (s == 8) ? 32'd5 : 32'd30);
         check("pend1", pend1, PendOn);
         check("pend2", pend2, 0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      check("stall_once", wb_stall, 0);
      check("replay", {27'd0, rf_addr}, 30);
      check("pend1_clear", pend1, 0);

      // reset with three entries queued
      @(posedge clk); #1;
      wb_addr = 5'd31; rd1_addr = 5'd10; rd2_addr = 5'd12;
      for (int i = 0; i < 3; i++) begin
         md_valid = 1'b1; md_addr = 5'(10 + i);
         md_data = 32'hE000_0000 + 32'(i); md_pc8 = 32'h0000_0600 + 32'(8 * i);
         @(posedge clk); #1;
      end
      md_valid = 1'b0;
      #1 reset = 1'b0;
      #1;
      sb_q.delete();
      check("mid_rf_we", rf_we, 0);
      check("mid_rf_addr", {27'd0, rf_addr}, 0);
      check("mid_rf_data", rf_data, 0);
      check("mid_rf_pc8", rf_pc8, 0);
      check("mid_md_ready", md_ready, 0);
      check("mid_wb_stall", wb_stall, 0);
      check("mid_pend", {pend1, pend2}, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1; wb_we = 1'b0;
      writes = 0;
      repeat (10) begin
         @(negedge clk);
         if (rf_we) writes++;
      end
      check("no_write_after_reset", writes, 0);
      check("post_reset_ready", md_ready, 1);
      check("sb_final", sb_q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
